// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and widths for the I/D-cache memory arbiter
//
// Purpose: state encodings, requester IDs, bus widths and the round-robin
// tie-break helper used by the arbiter and its bus interface.
// Ports: none (package).
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 28;   // 16-byte line address
  localparam int MEM_DATA_W = 128;  // one cache line per beat

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Winner among the pending requesters. On a tie the requester that was not
  // served last wins, so neither cache can monopolise the memory port.
  function automatic req_id_t pick_winner(logic req_i, logic req_d, req_id_t last);
    if (req_i && req_d)
      return (last == REQ_I) ? REQ_D : REQ_I;
    else if (req_d)
      return REQ_D;
    else
      return REQ_I;
  endfunction

  function automatic arb_state_t grant_state(req_id_t id);
    return (id == REQ_D) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - one memory-side request/response port
//
// Purpose: bundles the read/write request and the rdata/ready response of a
// single memory port. Used for the I-cache side, the D-cache side and the
// main-memory side of the arbiter.
// Ports (signals):
//   read, write  request strobes, held by the requester until ready
//   addr, wdata  request address and write data
//   rdata        read data returned to the requester
//   ready        one-cycle completion pulse
// Modports: master drives the request, slave answers it.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                  read;
  logic                  write;
  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_DATA_W-1:0] wdata;
  logic [MEM_DATA_W-1:0] rdata;
  logic                  ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing main memory between I- and D-cache
//
// Purpose: grants the single memory port to one cache miss path at a time and
// holds the grant for the whole transaction. A dead RELEASE cycle follows each
// transaction so the finished cache can drop its request.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   i_port    slave port facing the I-cache miss path
//   d_port    slave port facing the D-cache miss path
//   mem_port  master port facing main memory
//   arb_busy  high whenever the FSM is not in IDLE (debug)
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  i_port,
  mem_arbiter_if.slave  d_port,
  mem_arbiter_if.master mem_port,
  output logic          arb_busy
);

  arb_state_t state;
  req_id_t    last_gnt;
  req_id_t    idle_winner;
  logic       req_i;
  logic       req_d;

  assign req_i       = i_port.read | i_port.write;
  assign req_d       = d_port.read | d_port.write;
  assign idle_winner = pick_winner(req_i, req_d, last_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= REQ_I;
      arb_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i || req_d) begin
            state    <= grant_state(idle_winner);
            arb_busy <= 1'b1;
          end
        end
        GNT_I: begin
          // No timeout: the grant is held until memory completes.
          if (mem_port.ready) begin
            last_gnt <= REQ_I;
            state    <= RELEASE;
          end
        end
        GNT_D: begin
          if (mem_port.ready) begin
            last_gnt <= REQ_D;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

  // Grant-selected mux. Outside a grant everything is zero, which also keeps
  // a stray mem_ready in IDLE/RELEASE from reaching either cache.
  always_comb begin
    mem_port.read  = 1'b0;
    mem_port.write = 1'b0;
    mem_port.addr  = '0;
    mem_port.wdata = '0;
    i_port.rdata   = '0;
    i_port.ready   = 1'b0;
    d_port.rdata   = '0;
    d_port.ready   = 1'b0;
    case (state)
      GNT_I: begin
        mem_port.read  = i_port.read;
        mem_port.write = i_port.write;
        mem_port.addr  = i_port.addr;
        mem_port.wdata = i_port.wdata;
        i_port.rdata   = mem_port.rdata;
        i_port.ready   = mem_port.ready;
      end
      GNT_D: begin
        mem_port.read  = d_port.read;
        mem_port.write = d_port.write;
        mem_port.addr  = d_port.addr;
        mem_port.wdata = d_port.wdata;
        d_port.rdata   = mem_port.rdata;
        d_port.ready   = mem_port.ready;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // A granted cache must keep requesting until its ready pulse.
  a_i_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == GNT_I) |-> req_i);
  a_d_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == GNT_D) |-> req_d);
  // Read and write together from one cache is illegal; it is still forwarded.
  a_i_rw: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_port.read && i_port.write));
  a_d_rw: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_port.read && d_port.write));
`endif

endmodule
